matrix_result_streamer: RTL and testbench
=========================================

// Module: matrix_result_streamer
// PURPOSE
//  Drains the flattened 5x3 result bus of the iterative matrix multiplier.
//  - Captures MatrixResult on each Finished low->high transition.
//  - Streams the 15 elements out one per valid/ready handshake, row-major, tagged with row/col.
//  - Sits between the multiplier and downstream consumers (UART/display/accumulator).
// PARAMETERS
//  ROWS   5   result rows
//  COLS   3   result columns
//  WIDTH  15  bits per element
// PORTS
//  Clk           in   1                 single clock, rising edge
//  Reset         in   1                 asynchronous, active-high
//  MatrixResult  in   ROWS*COLS*WIDTH   flattened result (225b at defaults)
//  Finished      in   1                 multiplier done level
//  ElemData      out  WIDTH             current element
//  ElemRow       out  3                 row index of ElemData, 0..ROWS-1
//  ElemCol       out  2                 col index of ElemData, 0..COLS-1
//  ElemValid     out  1                 ElemData/Row/Col valid
//  ElemLast      out  1                 high with the final element (row 4, col 2)
//  ElemReady     in   1                 consumer accepts when ElemValid & ElemReady
//  Busy          out  1                 frame held or streaming
//  Overrun       out  1                 sticky: new frame arrived while busy, dropped
// BEHAVIOUR
//  - Clock and reset: one clock Clk. Reset is asynchronous, active-high; asserting it mid-frame aborts that frame immediately.
//  - Reset values: state IDLE; all outputs 0; FinishedQ (registered Finished) = 1.
//  - Start-up trigger: FinishedQ resets to 1, so a Finished held high out of reset never triggers. A low sample is required first.
//  - Rise condition: Finished & ~FinishedQ, sampled at Clk.
//  - Element order: element k (k = row*COLS + col) = MatrixResult[WIDTH*(ROWS*COLS-k)-1 -: WIDTH].
//    Result[0][0] occupies bits [224:210]; Result[4][2] occupies bits [14:0].
//  - FSM: IDLE, STREAM.
//    IDLE: on rise, load the 225b holding register, row = col = 0, go to STREAM.
//      ElemValid goes high the cycle after the capturing edge (latency 1).
//    STREAM: ElemValid = 1. ElemData = holding[row][col], combinational from the registered index.
//      - Handshake: col++. At col == COLS-1, col = 0 and row++.
//      - Handshake with ElemLast: return to IDLE.
//  - Handshake rules:
//    - ElemValid never drops before its handshake.
//    - ElemData, ElemRow and ElemCol are stable while ElemValid & ~ElemReady.
//    - ElemReady is ignored while ElemValid = 0.
//    - Back-to-back handshakes give 1 element/cycle; a full frame takes 15 cycles at ElemReady = 1.
//  - ElemLast = STREAM & row == ROWS-1 & col == COLS-1.
//  - Busy = (state == STREAM).
//  - Capture: only the holding register feeds ElemData. Later changes on MatrixResult are ignored until the next accepted rise.
//  - Boundary: rise in the same cycle as the last handshake is accepted. Capture the new frame, index = 0, stay in STREAM, no Overrun.
//  - Boundary: rise in STREAM at any other time: frame dropped, Overrun = 1. Overrun clears only on Reset.
//  - Boundary: Finished held high across frames produces no retrigger. A new frame needs Finished to go low then high.
//  - No arithmetic beyond the index counters. Index wrap is explicit (col 2 -> 0), with no reliance on 2-bit overflow.
// STRUCTURE
//  - Package matrix_pkg:
//    - ROWS, COLS, WIDTH, RESULT_W = ROWS*COLS*WIDTH, ROW_W = 3, COL_W = 2.
//    - State enum {IDLE, STREAM}.
//  - One sub-module: matrix_elem_counter (row/col counter).
//    - Inputs: clear, advance.
//    - Outputs: row, col, last.
//    - Shareable with a future operand loader.
//  - Holding register, edge detector and FSM live in the top module.
// TESTING
//  1. Reset with Finished = 1, then release -> no ElemValid for 20 cycles. Drop Finished, then raise it -> stream starts.
//  2. Result[r][c] = 10*r + c, ElemReady = 1 -> 15 beats 0,1,2,10,...,42 on consecutive cycles. ElemLast only on 42 (row 4, col 2). Busy low after the last beat.
//  3. Toggle ElemReady 1/0 every cycle -> data, row and col held while not ready. All 15 beats are in order, with no duplicates or drops.
//  4. Drive a second rise at beat 5 -> Overrun = 1, first frame completes intact, second frame not streamed. Drive a rise exactly on the last handshake -> new frame streamed, Overrun unchanged.
//  5. Assert Reset asynchronously mid-frame (between edges, at beat 7) -> ElemValid, Busy and Overrun go 0 before the next edge. The next rise streams from row 0, col 0.
//  6. Change MatrixResult during streaming -> output still matches the value captured at the rise.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared sizing and state encoding for the matrix result path.
package matrix_pkg;

    localparam int ROWS     = 5;
    localparam int COLS     = 3;
    localparam int WIDTH    = 15;
    localparam int RESULT_W = ROWS * COLS * WIDTH;
    localparam int ROW_W    = 3;
    localparam int COL_W    = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/matrix_elem_counter.sv
// Row-major row/col index counter over a ROWS x COLS matrix.
// clear has priority over advance. Both wraps are explicit compares,
// so the design never depends on natural counter overflow.
module matrix_elem_counter
    import matrix_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_end;
    logic             w_row_end;

    assign w_col_end = (r_col == COL_W'(COLS - 1));
    assign w_row_end = (r_row == ROW_W'(ROWS - 1));

    // Index register: clear to (0,0), else step col, carrying into row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_col_end & w_row_end;

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures the flattened multiplier result on a rising Finished and streams
// the elements out row-major, one per valid/ready handshake.
//
// Handshake: a beat transfers on a rising clock when o_elem_valid and
// i_elem_ready are both high. o_elem_valid never drops before its transfer,
// data/row/col/last hold steady while valid & ~ready, and i_elem_ready is
// ignored while valid is low.
module matrix_result_streamer
    import matrix_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [RESULT_W-1:0] i_matrix_result,
    input  logic                i_finished,
    output logic [WIDTH-1:0]    o_elem_data,
    output logic [ROW_W-1:0]    o_elem_row,
    output logic [COL_W-1:0]    o_elem_col,
    output logic                o_elem_valid,
    output logic                o_elem_last,
    input  logic                i_elem_ready,
    output logic                o_busy,
    output logic                o_overrun,
    output logic                o_dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_finished_q;
    logic [RESULT_W-1:0] r_hold;
    logic                r_overrun;

    logic                w_rise;
    logic                w_handshake;
    logic                w_last_hs;
    logic                w_capture;
    logic                w_drop;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;
    logic                w_cnt_last;
    logic [WIDTH-1:0]    w_elem;

    // Finished resets high so a level already high out of reset is not a rise.
    assign w_rise      = i_finished & ~r_finished_q;
    assign w_handshake = (r_state == STREAM) & i_elem_ready;
    assign w_last_hs   = w_handshake & w_cnt_last;
    // A rise while streaming is lost unless it lands on the final handshake.
    assign w_drop      = w_rise & (r_state == STREAM) & ~w_last_hs;

    matrix_elem_counter u_counter (
        .i_clk     (i_clk),
        .i_rst     (i_reset),
        .i_clear   (w_capture),
        .i_advance (w_handshake),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_cnt_last)
    );

    // Edge-detector history of Finished.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_finished_q <= 1'b1;
        end else begin
            r_finished_q <= i_finished;
        end
    end

    // Holding register: the only source of element data, loaded on accepted rises.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= i_matrix_result;
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and capture decision.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_next_state = STREAM;
                    w_capture    = 1'b1;
                end
            end
            STREAM: begin
                if (w_last_hs) begin
                    if (w_rise) begin
                        w_capture = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Element select: plain mux over the held frame, Result[0][0] in the MSBs.
    always_comb begin
        w_elem = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (w_row == ROW_W'(r) && w_col == COL_W'(c)) begin
                    w_elem = r_hold[WIDTH*(ROWS*COLS-(r*COLS+c))-1 -: WIDTH];
                end
            end
        end
    end

    // FSM outputs; element fields read as zero outside a stream.
    always_comb begin
        o_elem_valid = 1'b0;
        o_busy       = 1'b0;
        o_elem_last  = 1'b0;
        o_elem_data  = '0;
        o_elem_row   = '0;
        o_elem_col   = '0;
        if (r_state == STREAM) begin
            o_elem_valid = 1'b1;
            o_busy       = 1'b1;
            o_elem_last  = w_cnt_last;
            o_elem_data  = w_elem;
            o_elem_row   = w_row;
            o_elem_col   = w_col;
        end
    end

    assign o_overrun   = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a beat scoreboard.
module tb_matrix_result_streamer;

    localparam int ROWS  = 5;
    localparam int COLS  = 3;
    localparam int WIDTH = 15;
    localparam int RW    = ROWS * COLS * WIDTH;
    localparam int BW    = WIDTH + 3 + 2 + 1;

    logic            clk;
    logic            rst;
    logic [RW-1:0]   matrix;
    logic            finished;
    logic [WIDTH-1:0] elem_data;
    logic [2:0]      elem_row;
    logic [1:0]      elem_col;
    logic            elem_valid;
    logic            elem_last;
    logic            elem_ready;
    logic            busy;
    logic            overrun;
    logic            dbg_state;

    int checks;
    int errors;

    logic [BW-1:0] exp_q[$];

    matrix_result_streamer dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_matrix_result (matrix),
        .i_finished      (finished),
        .o_elem_data     (elem_data),
        .o_elem_row      (elem_row),
        .o_elem_col      (elem_col),
        .o_elem_valid    (elem_valid),
        .o_elem_last     (elem_last),
        .i_elem_ready    (elem_ready),
        .o_busy          (busy),
        .o_overrun       (overrun),
        .o_dbg_state     (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Row-major frame: first element built lands in the top bits.
    function automatic logic [RW-1:0] make_matrix(input int base);
        logic [RW-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m = {m[RW-WIDTH-1:0], WIDTH'(base + 10 * r + c)};
        return m;
    endfunction

    function automatic logic [RW-1:0] random_matrix();
        logic [RW-1:0] m;
        m = '0;
        for (int k = 0; k < ROWS * COLS; k++)
            m = {m[RW-WIDTH-1:0], WIDTH'($urandom_range(0, 32767))};
        return m;
    endfunction

    task automatic push_frame(input int base);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({WIDTH'(base + 10 * r + c), 3'(r), 2'(c),
                                 (r == ROWS - 1 && c == COLS - 1)});
    endtask

    // Finished low for one cycle, then high with a new frame; returns just after the capture edge.
    task automatic raise_frame(input int base);
        @(posedge clk); #1;
        finished = 1'b0;
        @(posedge clk); #1;
        matrix   = make_matrix(base);
        finished = 1'b1;
        push_frame(base);
        @(posedge clk); #1;
        check("latency_valid", 32'(elem_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, 32'(busy), 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard monitor: pops on each handshake, checks hold-steady while stalled
    logic          held_v;
    logic [BW-1:0] held;
    initial held_v = 1'b0;

    always @(negedge clk) begin
        logic [BW-1:0] got;
        got = {elem_data, elem_row, elem_col, elem_last};
        if (held_v && elem_valid)
            check("stall_stable", 32'(got), 32'(held));
        held_v = elem_valid & ~elem_ready;
        held   = got;
        if (elem_valid && elem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(got), 32'h1fffff);
            end else begin
                check("beat", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int seen_valid;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        finished   = 1'b1;
        elem_ready = 1'b0;
        matrix     = make_matrix(0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(elem_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_last", 32'(elem_last), 32'd0);
        check("rst_data", 32'(elem_data), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // Finished held high out of reset must not trigger
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (elem_valid) seen_valid++;
        end
        check("no_start_trigger", 32'(seen_valid), 32'd0);

        // full-rate frame: 15 beats on consecutive cycles
        elem_ready = 1'b1;
        raise_frame(0);
        check("first_row", 32'(elem_row), 32'd0);
        check("first_col", 32'(elem_col), 32'd0);
        check("first_data", 32'(elem_data), 32'd0);
        n = 1;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            if (busy) n++;
        end
        check("full_rate_cycles", 32'(n), 32'd15);
        wait_idle("frame0", 5);

        // Finished stays high: no retrigger
        repeat (5) @(posedge clk);
        #1;
        check("no_retrigger", 32'(busy), 32'd0);

        // ready toggling, MatrixResult changed after capture
        elem_ready = 1'b0;
        raise_frame(100);
        matrix = random_matrix();
        for (int i = 0; i < 60 && busy; i++) begin
            elem_ready = ~elem_ready;
            @(posedge clk); #1;
        end
        wait_idle("toggle", 5);
        check("toggle_no_overrun", 32'(overrun), 32'd0);

        // second rise mid-frame is dropped and flags overrun
        elem_ready = 1'b1;
        raise_frame(200);
        finished = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        matrix   = make_matrix(900);
        finished = 1'b1;
        @(posedge clk); #1;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_idle("dropped", 30);

        // rise exactly on the last handshake is accepted
        raise_frame(300);
        @(posedge clk); #1;
        finished = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check("pre_last_flag", 32'(elem_last), 32'd1);
        matrix   = make_matrix(400);
        finished = 1'b1;
        push_frame(400);
        @(posedge clk); #1;
        check("chain_busy", 32'(busy), 32'd1);
        check("chain_row", 32'(elem_row), 32'd0);
        check("chain_col", 32'(elem_col), 32'd0);
        check("chain_data", 32'(elem_data), 32'd400);
        check("chain_overrun_kept", 32'(overrun), 32'd1);
        wait_idle("chain", 30);

        // asynchronous reset mid-frame
        raise_frame(500);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(elem_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        raise_frame(600);
        check("post_reset_row", 32'(elem_row), 32'd0);
        check("post_reset_col", 32'(elem_col), 32'd0);
        wait_idle("post_reset", 30);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
